// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA definitions: instruction field layout and opcode constants
// used by the fetch unit and the pipeline decode stages.
package instr_fetch_unit_pkg;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;

    localparam int OPCODE_LSB = 26;
    localparam int RD_LSB     = 21;
    localparam int RS_LSB     = 16;
    localparam int RT_LSB     = 11;
    localparam int SA_LSB     = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    sa;
        logic [FUNCT_W-1:0]  funct;
    } fields_t;

    function automatic fields_t decode(input logic [31:0] word);
        fields_t f;
        f.opcode = word[OPCODE_LSB +: OPCODE_W];
        f.rd     = word[RD_LSB +: REG_W];
        f.rs     = word[RS_LSB +: REG_W];
        f.rt     = word[RT_LSB +: REG_W];
        f.sa     = word[SA_LSB +: REG_W];
        f.funct  = word[FUNCT_LSB +: FUNCT_W];
        return f;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_ram.sv
// Instruction memory: one sync write port, one sync read port.
// Reads sample the array before a same-edge write lands.
module instr_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array has no reset so loaded programs survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, program-loadable instruction RAM, registered
// fetched word with its PC and combinational field decode.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic [5:0]        opcode,
    output logic [4:0]        rd,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        sa,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic              is_rtype
);

    logic [ADDR_W-1:0] pc;
    logic              advance;
    fields_t           f;

    assign advance = fetch_en & ~stall & ~br_valid;

    instr_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (ld_we),
        .waddr(ld_addr),
        .wdata(ld_data),
        .re   (advance),
        .raddr(pc),
        .rdata(instr)
    );

    // Redirect wins over stall/enable; instr and instr_pc keep the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (br_valid) begin
            pc          <= br_target;
            instr_valid <= 1'b0;
        end else if (advance) begin
            pc          <= pc + ADDR_W'(1);
            instr_pc    <= pc;
            instr_valid <= 1'b1;
        end
    end

    assign f        = decode(instr[31:0]);
    assign opcode   = f.opcode;
    assign rd       = f.rd;
    assign rs       = f.rs;
    assign rt       = f.rt;
    assign sa       = f.sa;
    assign funct    = f.funct;
    assign imm      = instr[IMM_LSB +: IMM_W];
    assign is_rtype = (f.opcode == OP_RTYPE);

endmodule
